// File: rtl/mult_result_serializer.sv
// Serializes a 256-bit multiplier product into eight 32-bit words over a valid/ready link.
// Optional RESULT_PARITY_EN adds an even-parity bit (XOR of word_data).
module mult_result_serializer #(
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         mul_ready,
  input  logic [255:0] mul_out,
  output logic         word_valid,
  output logic [31:0]  word_data,
  input  logic         word_ready,
  output logic         word_last,
  output logic         busy,
  output logic         overrun
`ifdef RESULT_PARITY_EN
  ,
  output logic         word_parity
`endif
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [2:0]          idx;
  logic [2:0]          idx_n;
  logic [7:0][31:0]    shadow;
  logic [7:0][31:0]    shadow_n;
  logic                mul_ready_q;
  logic                overrun_n;
  logic                cap;
  logic                hs;
  logic                at_last;
  logic [2:0]          k;

  assign cap     = mul_ready & ~mul_ready_q;
  assign busy    = (state == SEND);
  assign hs      = busy & word_ready;
  assign at_last = (idx == 3'd7);

  // Reset value 1 masks a level already high at reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= 3'd0;
      shadow      <= '0;
      mul_ready_q <= 1'b1;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      shadow      <= shadow_n;
      mul_ready_q <= mul_ready;
      overrun     <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    shadow_n  = shadow;
    overrun_n = overrun;
    unique case (state)
      IDLE: begin
        if (cap) begin
          shadow_n = mul_out;
          idx_n    = 3'd0;
          state_n  = SEND;
        end
      end
      SEND: begin
        unique case (1'b1)
          hs && at_last: begin
            idx_n = 3'd0;
            if (cap) begin
              shadow_n = mul_out;
            end else begin
              state_n = IDLE;
            end
          end
          default: begin
            if (hs) begin
              idx_n = idx + 3'd1;
            end
            // Result arriving mid-stream is dropped.
            if (cap) begin
              overrun_n = 1'b1;
            end
          end
        endcase
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign k          = MSW_FIRST ? ~idx : idx;
  assign word_valid = busy;
  assign word_last  = busy & at_last;
  assign word_data  = busy ? shadow[k] : 32'd0;

`ifdef RESULT_PARITY_EN
  assign word_parity = ^word_data;
`endif

endmodule

// File: tb/tb_mult_result_serializer.sv
// Bench for mult_result_serializer: both word orders side by side,
// checked every cycle against a queue-based model of the result stream.
module tb_mult_result_serializer;

  logic         clock;
  logic         reset_n;
  logic         mul_ready;
  logic [255:0] mul_out;
  logic         word_ready;

  logic         v0, l0, b0, o0;
  logic         v1, l1, b1, o1;
  logic [31:0]  d0, d1;
`ifdef RESULT_PARITY_EN
  logic         p0, p1;
`endif

  int n_chk;
  int n_fail;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        m_ovr;
  logic        m_prev;

  mult_result_serializer #(.MSW_FIRST(1'b0)) dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .mul_ready  (mul_ready),
    .mul_out    (mul_out),
    .word_valid (v0),
    .word_data  (d0),
    .word_ready (word_ready),
    .word_last  (l0),
    .busy       (b0),
    .overrun    (o0)
`ifdef RESULT_PARITY_EN
    ,
    .word_parity(p0)
`endif
  );

  mult_result_serializer #(.MSW_FIRST(1'b1)) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .mul_ready  (mul_ready),
    .mul_out    (mul_out),
    .word_valid (v1),
    .word_data  (d1),
    .word_ready (word_ready),
    .word_last  (l1),
    .busy       (b1),
    .overrun    (o1)
`ifdef RESULT_PARITY_EN
    ,
    .word_parity(p1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ovr  = 1'b0;
    m_prev = 1'b1;
  endtask

  // A new result is taken only if the stream is empty after this edge's handshake.
  task automatic model_edge();
    logic cap;
    cap = mul_ready && !m_prev;
    if (q0.size() > 0 && word_ready) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (cap) begin
      if (q0.size() == 0) begin
        for (int i = 0; i < 8; i++) begin
          q0.push_back(mul_out[32*i +: 32]);
          q1.push_back(mul_out[32*(7-i) +: 32]);
        end
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_prev = mul_ready;
  endtask

  task automatic check_all();
    logic        ev;
    logic        el;
    logic [31:0] e0;
    logic [31:0] e1;
    ev = (q0.size() > 0);
    el = (q0.size() == 1);
    e0 = ev ? q0[0] : 32'd0;
    e1 = ev ? q1[0] : 32'd0;
    chk("lsw.valid", {31'd0, v0}, {31'd0, ev});
    chk("lsw.data", d0, e0);
    chk("lsw.last", {31'd0, l0}, {31'd0, el});
    chk("lsw.busy", {31'd0, b0}, {31'd0, ev});
    chk("lsw.overrun", {31'd0, o0}, {31'd0, m_ovr});
    chk("msw.valid", {31'd0, v1}, {31'd0, ev});
    chk("msw.data", d1, e1);
    chk("msw.last", {31'd0, l1}, {31'd0, el});
    chk("msw.busy", {31'd0, b1}, {31'd0, ev});
    chk("msw.overrun", {31'd0, o1}, {31'd0, m_ovr});
`ifdef RESULT_PARITY_EN
    chk("lsw.parity", {31'd0, p0}, {31'd0, ^e0});
    chk("msw.parity", {31'd0, p1}, {31'd0, ^e1});
`endif
  endtask

  task automatic cyc(input logic mr, input logic wr);
    mul_ready  = mr;
    word_ready = wr;
    @(posedge clock);
    if (reset_n) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc(mul_ready, word_ready);
    reset_n = 1'b1;
  endtask

  function automatic logic [255:0] seq_words();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = 32'(i + 1);
    return v;
  endfunction

  function automatic logic [255:0] rnd_words();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    mul_ready  = 1'b0;
    word_ready = 1'b0;
    mul_out    = '0;
    model_reset();
    #2;
    check_all();
    cyc(1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1);

    // Sequential words, both orders, full-rate drain.
    mul_out = seq_words();
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);

    // Back-pressure after the first word.
    mul_out = rnd_words();
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);

    // Second result during word 3 is dropped.
    mul_out = seq_words();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    mul_out = rnd_words();
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
    pulse_reset();
    cyc(1'b0, 1'b1);

    // Second result coincides with the last handshake.
    mul_out = seq_words();
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
    mul_out = rnd_words();
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);

    // Reset during word 5 with mul_ready held high.
    mul_out = seq_words();
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    pulse_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);

    // Parity of word 7 through the LSW-first instance.
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
    chk("word7.data", d0, 32'h7);
`ifdef RESULT_PARITY_EN
    chk("word7.parity", {31'd0, p0}, 32'd1);
`endif
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      mul_out = rnd_words();
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 150) == 0) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_result_serializer.md
MULT_RESULT_SERIALIZER -- requirements
Module: mult_result_serializer

Interface
REQ-001 SHALL have parameter MSW_FIRST, default 0; 0 emits bits 31:0 first, 1 emits bits 255:224 first.
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port mul_ready  input  1  multiplier result-ready level.
REQ-005 SHALL have port mul_out  input  256  multiplier product.
REQ-006 SHALL have port word_valid  output  1  output word available.
REQ-007 SHALL have port word_data  output  32  current output word.
REQ-008 SHALL have port word_ready  input  1  downstream accepts word.
REQ-009 SHALL have port word_last  output  1  current word is the 8th of the result.
REQ-010 SHALL have port busy  output  1  serializer holds an unsent result.
REQ-011 SHALL have port overrun  output  1  sticky flag for a dropped result.
REQ-012 SHALL have port word_parity  output  1  only when RESULT_PARITY_EN is defined.

Function
REQ-013 SHALL register mul_ready into mul_ready_q; capture event = mul_ready & ~mul_ready_q at a clock edge.
REQ-014 SHALL use states IDLE and SEND.
REQ-015 IDLE + capture event: SHALL load mul_out into a 256-bit shadow register, set idx=0, go to SEND.
REQ-016 In SEND, word_valid SHALL be 1, registered, and asserted the cycle after the capture edge (latency 1).
REQ-017 word_data SHALL be shadow[32*k+31:32*k], with k=idx if MSW_FIRST=0, else k=7-idx.
REQ-018 word_data SHALL remain stable while word_valid=1 and word_ready=0.
REQ-019 Handshake = word_valid & word_ready at a clock edge; each handshake SHALL increment idx.
REQ-020 word_last SHALL be 1 exactly when in SEND and idx==7.
REQ-021 Handshake at idx==7 with no capture event SHALL return to IDLE; word_valid=0 the next cycle.
REQ-022 Capture event coinciding with the idx==7 handshake SHALL load the new result, set idx=0, stay in SEND, and not set overrun.
REQ-023 Any other capture event in SEND SHALL drop the new result, leave shadow and idx unchanged, and set overrun.
REQ-024 overrun SHALL stay 1 until reset.
REQ-025 mul_ready held high SHALL cause exactly one capture.
REQ-026 busy SHALL equal (state==SEND).
REQ-027 word_valid, word_last and word_data SHALL be 0 in IDLE.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, idx=0, shadow=0, overrun=0, word_valid=0, word_last=0, busy=0, word_data=0.
REQ-029 mul_ready_q SHALL reset to 1, so a mul_ready level already high at reset release is not captured.
REQ-030 Reset during SEND SHALL discard the in-flight result; no further words SHALL be emitted.

Configuration
REQ-031 Macro RESULT_PARITY_EN defined: word_parity port SHALL exist, equal to the XOR of word_data (0 in IDLE), and follow word_data combinationally.
REQ-032 Macro RESULT_PARITY_EN undefined: word_parity port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 MSW_FIRST=0, mul_out words W0..W7=32'h1..32'h8 (W0=bits 31:0), mul_ready 0->1, word_ready=1 -> words 1..8 on 8 consecutive cycles, word_last only with 8, then IDLE.
REQ-034 Same data with MSW_FIRST=1 -> words 8..1, word_last with word 1.
REQ-035 word_ready=0 for 5 cycles after the first word -> word_data holds 32'h1 and idx does not advance; the sequence resumes when word_ready=1.
REQ-036 Second mul_ready rising edge during word 3 -> overrun=1, original words 4..8 still emitted, second result never emitted.
REQ-037 Second rising edge on the same edge as the word-8 handshake -> overrun=0, the new result is emitted starting next cycle.
REQ-038 reset_n pulsed low during word 5 -> all outputs 0 immediately; mul_ready still high after release -> no capture; with RESULT_PARITY_EN, word 32'h7 gives word_parity=1.
